// File: rtl/bidir_bus_ctrl.sv
// Transaction sequencer for the 8-bit bidirectional pad stage: turns single-byte
// read/write requests into timed bus cycles with a programmable turnaround gap.
module bidir_bus_ctrl #(
  parameter int unsigned TURNAROUND = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       oe,
  output logic [7:0] inp,
  input  logic [7:0] outp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WLOAD,
    S_WDRIVE,
    S_RDRIVE,
    S_RCAP,
    S_TURN
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURNAROUND);
  localparam bit         HAS_TURN  = (TURNAROUND != 0);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       oe_q, oe_d;
  logic [7:0] inp_q, inp_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      inp_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      oe_q        <= oe_d;
      inp_q       <= inp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // oe is a flop, so it is raised on the WLOAD->WDRIVE edge and dropped on the next one.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    oe_d        = 1'b0;
    inp_d       = inp_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_write) begin
            state_d = S_WLOAD;
            inp_d   = req_data;
          end else begin
            state_d = S_RDRIVE;
          end
        end
      end
      S_WLOAD: begin
        state_d = S_WDRIVE;
        oe_d    = 1'b1;
      end
      S_WDRIVE: begin
        if (HAS_TURN) begin
          state_d = S_TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RDRIVE: begin
        state_d = S_RCAP;
      end
      S_RCAP: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = outp;
        if (HAS_TURN) begin
          state_d = S_TURN;
          cnt_d   = TURN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_TURN: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE) && !rst;
  assign oe        = oe_q;
  assign inp       = inp_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Bench for bidir_bus_ctrl: three instances (TURNAROUND 1, 2, 0), each with a pad-stage
// and device model, a timing reference model and an output scoreboard.
module tb_bidir_bus_ctrl;

  localparam int N = 3;
  localparam int TA [N] = '{1, 2, 0};

  typedef struct {
    bit         is_rd;
    int         cyc;
    logic [7:0] data;
  } ev_t;

  logic       clk;
  logic       rst       [N];
  logic       req_valid [N];
  logic       req_ready [N];
  logic       req_write [N];
  logic [7:0] req_data  [N];
  logic       rsp_valid [N];
  logic [7:0] rsp_data  [N];
  logic       oe        [N];
  logic [7:0] inp       [N];
  logic [7:0] pad_a     [N];
  logic [7:0] pad_b     [N];
  logic [7:0] bus       [N];
  logic       dev_en    [N];
  logic [7:0] dev_data  [N];
  logic [7:0] dev_val   [N];

  int         checks;
  int         failures;
  int         cyc;
  ev_t        sbq       [N][$];
  int         free_cyc  [N];
  int         last_oe   [N];
  logic [7:0] inp_exp   [N];
  logic [7:0] rsp_exp   [N];
  bit         rd_pend   [N];
  logic [7:0] dev_lat   [N];

  for (genvar g = 0; g < N; g++) begin : gen_dut
    bidir_bus_ctrl #(.TURNAROUND(TA[g])) u_dut (
      .clk      (clk),
      .rst      (rst[g]),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_write(req_write[g]),
      .req_data (req_data[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_data (rsp_data[g]),
      .oe       (oe[g]),
      .inp      (inp[g]),
      .outp     (pad_b[g])
    );

    // Pad stage: registered output side and registered bus sample; device pulls up when idle.
    assign bus[g] = oe[g] ? pad_a[g] : (dev_en[g] ? dev_data[g] : 8'hFF);

    always @(posedge clk) begin
      pad_a[g]    <= inp[g];
      pad_b[g]    <= bus[g];
      dev_en[g]   <= rd_pend[g];
      dev_data[g] <= dev_lat[g];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input int k, input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=0x%0h required=0x%0h cycle=%0d", nm, k, act, exp, cyc);
    end
  endfunction

  // Monitor / reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    ev_t ev;
    for (int k = 0; k < N; k++) begin
      if (rst[k]) begin
        chk(k, "rst_oe", int'(oe[k]), 0);
        chk(k, "rst_inp", int'(inp[k]), 0);
        chk(k, "rst_rsp_valid", int'(rsp_valid[k]), 0);
        chk(k, "rst_rsp_data", int'(rsp_data[k]), 0);
        chk(k, "rst_req_ready", int'(req_ready[k]), 0);
        sbq[k].delete();
        free_cyc[k] = 0;
        inp_exp[k]  = 8'h00;
        rsp_exp[k]  = 8'h00;
        rd_pend[k]  = 1'b0;
        last_oe[k]  = -100;
      end else begin
        if (oe[k] || rsp_valid[k]) begin
          if (sbq[k].size() == 0) begin
            chk(k, "unexpected_output", int'({oe[k], rsp_valid[k]}), 0);
          end else begin
            ev = sbq[k].pop_front();
            chk(k, "event_kind", int'(rsp_valid[k]), int'(ev.is_rd));
            chk(k, "event_cycle", cyc, ev.cyc);
            if (ev.is_rd) begin
              chk(k, "rsp_data", int'(rsp_data[k]), int'(ev.data));
              rsp_exp[k] = ev.data;
            end else begin
              chk(k, "bus_write_data", int'(bus[k]), int'(ev.data));
            end
          end
        end else if (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
          chk(k, "missing_output", cyc, sbq[k][0].cyc);
          void'(sbq[k].pop_front());
        end
        chk(k, "rsp_data_hold", int'(rsp_data[k]), int'(rsp_exp[k]));
        chk(k, "inp", int'(inp[k]), int'(inp_exp[k]));
        chk(k, "req_ready", int'(req_ready[k]), int'(cyc >= free_cyc[k]));
        if (dev_en[k]) begin
          chk(k, "bus_conflict", int'(oe[k]), 0);
          chk(k, "turn_gap", int'((cyc - last_oe[k]) >= TA[k] + 2), 1);
        end
        if (oe[k]) last_oe[k] = cyc;
        rd_pend[k] = 1'b0;
        if (req_valid[k] && cyc >= free_cyc[k]) begin
          free_cyc[k] = cyc + 3 + TA[k];
          if (req_write[k]) begin
            sbq[k].push_back('{is_rd: 1'b0, cyc: cyc + 2, data: req_data[k]});
            inp_exp[k] = req_data[k];
          end else begin
            sbq[k].push_back('{is_rd: 1'b1, cyc: cyc + 3, data: dev_val[k]});
            rd_pend[k] = 1'b1;
            dev_lat[k] = dev_val[k];
          end
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic txn(input int k, input bit wr, input logic [7:0] d, input logic [7:0] dv);
    int w;
    req_write[k] = wr;
    req_data[k]  = d;
    dev_val[k]   = dv;
    req_valid[k] = 1'b1;
    w = 0;
    @(negedge clk);
    while (!req_ready[k] && w < 64) begin
      @(negedge clk);
      w++;
    end
    if (w >= 64) chk(k, "accept_timeout", w, 0);
    @(posedge clk);
    #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int c);
    if (c > 0) begin
      repeat (c) @(posedge clk);
      #1;
    end
  endtask

  task automatic run(input int k);
    logic [7:0] d;
    logic [7:0] v;
    txn(k, 1'b1, 8'hA5, 8'h00);
    idle(k, 6);
    txn(k, 1'b0, 8'h00, 8'h3C);
    idle(k, 6);
    txn(k, 1'b1, 8'h11, 8'h00);
    txn(k, 1'b0, 8'h00, 8'h22);
    idle(k, 4);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      v = 8'($urandom);
      txn(k, (i % 2) == 0, d, v);
    end
    idle(k, 6);
    // Reset while the write is on the bus.
    txn(k, 1'b1, 8'h5A, 8'h00);
    @(posedge clk);
    #1;
    chk(k, "oe_in_wdrive", int'(oe[k]), 1);
    rst[k] = 1'b1;
    #1;
    chk(k, "oe_async_drop", int'(oe[k]), 0);
    chk(k, "inp_async_clear", int'(inp[k]), 0);
    repeat (2) @(posedge clk);
    #1;
    rst[k] = 1'b0;
    txn(k, 1'b1, 8'hC3, 8'h00);
    idle(k, 6);
    // Request raised during TURN and withdrawn on the cycle IDLE returns.
    if (TA[k] > 0) begin
      txn(k, 1'b1, 8'h6E, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      req_write[k] = 1'($urandom);
      req_data[k]  = 8'($urandom);
      dev_val[k]   = 8'($urandom);
      req_valid[k] = 1'b1;
      repeat (TA[k]) @(posedge clk);
      #1;
      req_valid[k] = 1'b0;
      idle(k, 4);
    end
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      v = 8'($urandom);
      txn(k, 1'($urandom), d, v);
      idle(k, int'($urandom_range(0, 2)));
    end
    idle(k, 12);
    chk(k, "scoreboard_drained", sbq[k].size(), 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    for (int k = 0; k < N; k++) begin
      rst[k]       = 1'b1;
      req_valid[k] = 1'b0;
      req_write[k] = 1'b0;
      req_data[k]  = 8'h00;
      dev_val[k]   = 8'h00;
      rd_pend[k]   = 1'b0;
      dev_lat[k]   = 8'h00;
      free_cyc[k]  = 0;
      last_oe[k]   = -100;
      inp_exp[k]   = 8'h00;
      rsp_exp[k]   = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    fork
      run(0);
      run(1);
      run(2);
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
